orders_and_points: RTL and testbench
====================================

# orders_and_points

Tracks the active customer orders, their countdown timers and the team score while a round is running. Sits beside the game-state controller: it reads `game_state` and a serve pulse from the action stage, and produces the `orders`, `order_times` and `point_total` values the controller forwards to the display and score-save logic. It has its own one-second timebase that runs only while the game is in the Start Game state.

## Interface
Parameters:
- `TICK_CYCLES`, default 100_000_000: clock cycles per game second.
- `SPAWN_PERIOD`, default 20: seconds between order spawns. Range 1–255.
- `ORDER_TIME`, default 30: initial lifetime of a new order, in seconds. Range 1–30.
- `SERVE_POINTS`, default 20: base reward for a served order.
- `EXPIRE_PENALTY`, default 10: deduction when an order expires.

Ports:
- `clock`, input, 1: system clock. One clock domain only.
- `reset`, input, 1: synchronous, active-high reset.
- `game_state`, input, 3: 0 welcome, 1 intro, 2 running, 3 paused, 4 finished.
- `serve`, input, 1: one-cycle pulse meaning a completed dish was delivered.
- `orders`, output, 4: active flag for each order slot.
- `order_times`, output, 4x5: seconds remaining for each slot. An inactive slot reads 5'b11111.
- `point_total`, output, 10: score, saturating between 0 and 1023.
- `serve_ack`, output, 1: one-cycle pulse one cycle after every accepted `serve`.
- `serve_hit`, output, 1: valid while `serve_ack` is high. 1 means an order was fulfilled.

## Operation
- Reset values: `orders`=0; all `order_times`=31; `point_total`=0; `serve_ack`=0; `serve_hit`=0; tick counter=0; spawn counter=1.
- `game_state` 1: every register is held at its reset value each cycle. This clears the board for the next round.
- `game_state` 0, 3 and 4: all state is frozen and the tick counter holds. `serve` is ignored and produces no ack.
- `game_state` 2: the tick counter increments every cycle.
  - When it equals `TICK_CYCLES`-1, it wraps to 0 and a tick fires in that same cycle.
  - Leaving state 2 mid-second resumes the count from the held value.
- On a tick:
  - Each active slot with time > 1 decrements by 1.
  - Each active slot with time == 1 expires: its flag clears, its time becomes 31, and `EXPIRE_PENALTY` is applied.
  - The spawn counter decrements. When it reaches 0 it reloads to `SPAWN_PERIOD` and an order is spawned.
- Spawning:
  - The new order goes into the lowest-index slot that was free before this cycle. That slot's flag is set and its time becomes `ORDER_TIME`.
  - If all 4 slots are full, the spawn is dropped and the counter still reloads.
  - Because the spawn counter resets to 1, the first order appears on the first tick of a round.
- Serving (only in `game_state` 2):
  - The target is the active slot with the smallest pre-cycle time. Ties go to the lowest index.
  - If there is a target: clear it, set its time to 31, and add `SERVE_POINTS` + its pre-cycle time. `serve_hit` is 1.
  - If no slot is active: the score is unchanged and `serve_hit` is 0.
- Simultaneous serve and tick:
  - The serve is evaluated on pre-tick values.
  - The served slot neither decrements nor expires.
  - Other slots tick normally.
  - A slot freed by this serve or by an expiry is not available to a spawn in the same cycle.
- Score arithmetic:
  - Signed 12-bit sum: `point_total` + serve reward − (number of expiries × `EXPIRE_PENALTY`).
  - Clamp the result to 0..1023, then register it.

## Timing
- Every output is registered. No output depends combinationally on an input.
- `serve` sampled on edge N: `orders`, `order_times` and `point_total` update, and `serve_ack`/`serve_hit` assert, together in the cycle after edge N. They remain valid for exactly 1 cycle.
- Back-to-back `serve` pulses are each processed, every cycle, against the previous cycle's state.
- A tick's effects are visible in the cycle after the counter reads `TICK_CYCLES`-1.
- Reset asserted mid-round: the next cycle shows reset values, and any pending ack is dropped.

## Test plan
Use `TICK_CYCLES`=10, `SPAWN_PERIOD`=3, `ORDER_TIME`=5.
- Reset, then `game_state` 1 → 2. After 10 cycles in state 2: `orders`=4'b0001, `order_times[0]`=5, all other slots 31, `point_total`=0.
- Let slot 0 run down with no serves. It expires on the tick when its time is 1: bit 0 clears, `order_times[0]`=31, and `point_total` stays 0 (floored). Run through the same expiry again with `point_total` preloaded to 15 by serves: it goes to 5.
- Slots 0 and 1 active with times 4 and 2; pulse `serve`. One cycle later: slot 1 is cleared, `point_total` increases by 22, `serve_ack`=1, `serve_hit`=1.
- Pulse `serve` with `orders`=0 → `serve_ack`=1, `serve_hit`=0, score unchanged. Pulse `serve` in `game_state` 3 → no `serve_ack`, and the timers stay frozen for 50 cycles.
- Fill all 4 slots. At the next spawn tick, `orders` stays 4'b1111 and the spawn counter reloads to 3. Serve coincident with a tick: the served slot is cleared, not decremented, and not respawned that same cycle.
- Drive `point_total` to 1020, then serve an order with time 5 → `point_total`=1023 (saturated).

Source files
------------

// File: rtl/orders_and_points.sv
`timescale 1ns/1ps
// orders_and_points
// -----------------
// Keeps the four customer order slots, their per-second countdowns and the
// team score while a round is being played. A private one-second timebase
// only advances while the game is running, so pausing freezes every timer.
//
// Ports
//   clock        : system clock (single domain)
//   reset        : synchronous, active-high reset
//   game_state   : 0 welcome, 1 intro, 2 running, 3 paused, 4 finished
//   serve        : one-cycle pulse, a finished dish was handed over
//   orders       : active flag per order slot
//   order_times  : seconds left per slot, 31 when the slot is empty
//   point_total  : score, saturating between 0 and 1023
//   serve_ack    : one-cycle pulse one cycle after each accepted serve
//   serve_hit    : qualifies serve_ack, 1 when an order was fulfilled
module orders_and_points #(
  parameter int TICK_CYCLES    = 100_000_000,
  parameter int SPAWN_PERIOD   = 20,
  parameter int ORDER_TIME     = 30,
  parameter int SERVE_POINTS   = 20,
  parameter int EXPIRE_PENALTY = 10
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [2:0]      game_state,
  input  logic            serve,
  output logic [3:0]      orders,
  output logic [3:0][4:0] order_times,
  output logic [9:0]      point_total,
  output logic            serve_ack,
  output logic            serve_hit
);

  typedef enum logic [2:0] {
    GS_WELCOME  = 3'd0,
    GS_INTRO    = 3'd1,
    GS_RUNNING  = 3'd2,
    GS_PAUSED   = 3'd3,
    GS_FINISHED = 3'd4
  } game_state_e;

  localparam int                TICK_W       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST    = TICK_W'(TICK_CYCLES - 1);
  localparam logic [4:0]        IDLE_TIME    = 5'd31;
  localparam logic [4:0]        ORDER_INIT   = 5'(ORDER_TIME);
  localparam logic [7:0]        SPAWN_RELOAD = 8'(SPAWN_PERIOD);
  localparam logic [11:0]       SERVE_BASE   = 12'(SERVE_POINTS);
  localparam logic [11:0]       PENALTY_UNIT = 12'(EXPIRE_PENALTY);
  localparam logic [9:0]        SCORE_MAX    = 10'd1023;

  // Registered state
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]        spawn_cnt_q, spawn_cnt_d;
  logic [3:0]        orders_q, orders_d;
  logic [3:0][4:0]   times_q, times_d;
  logic [9:0]        points_q, points_d;
  logic              ack_q, ack_d;
  logic              hit_q, hit_d;

  // Intermediate values for a running cycle
  logic              running;
  logic              tick;
  logic              serve_fire;
  logic [TICK_W-1:0] tick_cnt_run;
  logic              target_found;
  logic [1:0]        target_idx;
  logic [4:0]        target_time;
  logic              free_found;
  logic [1:0]        free_idx;
  logic              spawn_fire;
  logic [7:0]        spawn_cnt_run;
  logic [3:0]        orders_run;
  logic [3:0][4:0]   times_run;
  logic [2:0]        expire_cnt;
  logic [11:0]       reward;
  logic [11:0]       penalty;
  logic [11:0]       score_sum;
  logic [9:0]        points_run;

  // One-second timebase: counts only while running and fires on the last
  // count of the second, so a pause resumes mid-second where it left off.
  always_comb begin
    running      = (game_state == GS_RUNNING);
    serve_fire   = running && serve;
    tick         = running && (tick_cnt_q == TICK_LAST);
    tick_cnt_run = tick ? '0 : tick_cnt_q + TICK_W'(1);
  end

  // Serve target: the active slot with the least time left. The strict
  // less-than keeps the lowest index on ties.
  always_comb begin
    target_found = 1'b0;
    target_idx   = 2'd0;
    target_time  = IDLE_TIME;
    for (int i = 0; i < 4; i++) begin
      if (orders_q[i] && (!target_found || (times_q[i] < target_time))) begin
        target_found = 1'b1;
        target_idx   = 2'(i);
        target_time  = times_q[i];
      end
    end
  end

  // Spawn destination: lowest slot that was already empty before this cycle,
  // so slots freed by a serve or expiry this cycle are not reused until the
  // next spawn. Scanning downward leaves the lowest free index last.
  always_comb begin
    free_found = 1'b0;
    free_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!orders_q[i]) begin
        free_found = 1'b1;
        free_idx   = 2'(i);
      end
    end
  end

  // Spawn countdown in seconds; reloads whenever it runs out, even if the
  // board is full and the new order has nowhere to go.
  always_comb begin
    spawn_fire    = 1'b0;
    spawn_cnt_run = spawn_cnt_q;
    if (tick) begin
      if (spawn_cnt_q <= 8'd1) begin
        spawn_fire    = 1'b1;
        spawn_cnt_run = SPAWN_RELOAD;
      end else begin
        spawn_cnt_run = spawn_cnt_q - 8'd1;
      end
    end
  end

  // Slot update. The serve is judged on pre-tick values and the served slot
  // is excluded from this second's countdown; all other active slots count
  // down and expire when they would drop below one second.
  always_comb begin
    orders_run = orders_q;
    times_run  = times_q;
    expire_cnt = 3'd0;
    if (serve_fire && target_found) begin
      orders_run[target_idx] = 1'b0;
      times_run[target_idx]  = IDLE_TIME;
    end
    if (tick) begin
      for (int i = 0; i < 4; i++) begin
        if (orders_q[i] && !(serve_fire && target_found && (target_idx == 2'(i)))) begin
          if (times_q[i] > 5'd1) begin
            times_run[i] = times_q[i] - 5'd1;
          end else begin
            orders_run[i] = 1'b0;
            times_run[i]  = IDLE_TIME;
            expire_cnt    = expire_cnt + 3'd1;
          end
        end
      end
    end
    if (spawn_fire && free_found) begin
      orders_run[free_idx] = 1'b1;
      times_run[free_idx]  = ORDER_INIT;
    end
  end

  // Score: 12-bit sum of old score, serve reward and expiry penalties, read
  // as two's complement and clamped into the 10-bit display range.
  always_comb begin
    reward    = (serve_fire && target_found) ? (SERVE_BASE + {7'd0, target_time}) : 12'd0;
    penalty   = PENALTY_UNIT * {9'd0, expire_cnt};
    score_sum = {2'b00, points_q} + reward - penalty;
    if (score_sum[11]) begin
      points_run = 10'd0;
    end else if (score_sum > {2'b00, SCORE_MAX}) begin
      points_run = SCORE_MAX;
    end else begin
      points_run = score_sum[9:0];
    end
  end

  // Game-state gating: intro wipes the board for the next round, running
  // applies this cycle's updates, every other state freezes everything and
  // swallows serves without acknowledging them.
  always_comb begin
    tick_cnt_d  = tick_cnt_q;
    spawn_cnt_d = spawn_cnt_q;
    orders_d    = orders_q;
    times_d     = times_q;
    points_d    = points_q;
    ack_d       = 1'b0;
    hit_d       = 1'b0;
    case (game_state)
      GS_INTRO: begin
        tick_cnt_d  = '0;
        spawn_cnt_d = 8'd1;
        orders_d    = 4'd0;
        times_d     = {4{IDLE_TIME}};
        points_d    = 10'd0;
      end
      GS_RUNNING: begin
        tick_cnt_d  = tick_cnt_run;
        spawn_cnt_d = spawn_cnt_run;
        orders_d    = orders_run;
        times_d     = times_run;
        points_d    = points_run;
        ack_d       = serve_fire;
        hit_d       = serve_fire && target_found;
      end
      default: begin
      end
    endcase
  end

  // State register; reset drops any pending acknowledge.
  always_ff @(posedge clock) begin
    if (reset) begin
      tick_cnt_q  <= '0;
      spawn_cnt_q <= 8'd1;
      orders_q    <= 4'd0;
      times_q     <= {4{IDLE_TIME}};
      points_q    <= 10'd0;
      ack_q       <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      spawn_cnt_q <= spawn_cnt_d;
      orders_q    <= orders_d;
      times_q     <= times_d;
      points_q    <= points_d;
      ack_q       <= ack_d;
      hit_q       <= hit_d;
    end
  end

  assign orders      = orders_q;
  assign order_times = times_q;
  assign point_total = points_q;
  assign serve_ack   = ack_q;
  assign serve_hit   = hit_q;

endmodule

// File: tb/tb_orders_and_points.sv
`timescale 1ns/1ps
// Bench for orders_and_points. Instance A uses a short game second with slow
// spawns to exercise countdown, expiry, serving and pausing. Instance B
// spawns every second with long-lived orders and a large reward, so the
// board fills up and the score saturates quickly.
module tb_orders_and_points;

  localparam logic [19:0] ALL_IDLE = 20'hFFFFF;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            reset_a, serve_a, serve_ack_a, serve_hit_a;
  logic [2:0]      game_state_a;
  logic [3:0]      orders_a;
  logic [3:0][4:0] order_times_a;
  logic [9:0]      point_total_a;

  logic            reset_b, serve_b, serve_ack_b, serve_hit_b;
  logic [2:0]      game_state_b;
  logic [3:0]      orders_b;
  logic [3:0][4:0] order_times_b;
  logic [9:0]      point_total_b;

  orders_and_points #(
    .TICK_CYCLES(10), .SPAWN_PERIOD(3), .ORDER_TIME(5),
    .SERVE_POINTS(20), .EXPIRE_PENALTY(10)
  ) u_dut_a (
    .clock(clock), .reset(reset_a), .game_state(game_state_a), .serve(serve_a),
    .orders(orders_a), .order_times(order_times_a), .point_total(point_total_a),
    .serve_ack(serve_ack_a), .serve_hit(serve_hit_a)
  );

  orders_and_points #(
    .TICK_CYCLES(4), .SPAWN_PERIOD(1), .ORDER_TIME(30),
    .SERVE_POINTS(500), .EXPIRE_PENALTY(10)
  ) u_dut_b (
    .clock(clock), .reset(reset_b), .game_state(game_state_b), .serve(serve_b),
    .orders(orders_b), .order_times(order_times_b), .point_total(point_total_b),
    .serve_ack(serve_ack_b), .serve_hit(serve_hit_b)
  );

  typedef struct {
    string       tag;
    bit          inst;
    logic [3:0]  orders;
    logic [19:0] times;
    logic [9:0]  points;
    logic        ack;
    logic        hit;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Packs per-slot expected times, slot 3 in the top bits.
  function automatic logic [19:0] tv(input int s3, input int s2, input int s1, input int s0);
    return {5'(s3), 5'(s2), 5'(s1), 5'(s0)};
  endfunction

  // Queues the expected outputs for the stimulus about to be applied.
  task automatic pushExpect(input string tag, input bit inst, input int o,
                            input logic [19:0] t, input int p, input int a, input int h);
    exp_t e;
    e.tag    = tag;
    e.inst   = inst;
    e.orders = 4'(o);
    e.times  = t;
    e.points = 10'(p);
    e.ack    = 1'(a);
    e.hit    = 1'(h);
    sb_q.push_back(e);
  endtask

  // Drives one instance's inputs at a falling edge and lets it run.
  task automatic applyStimulus(input bit inst, input logic rst, input logic [2:0] gs,
                               input logic srv, input int cycles);
    if (inst == 1'b0) begin
      reset_a = rst; game_state_a = gs; serve_a = srv;
    end else begin
      reset_b = rst; game_state_b = gs; serve_b = srv;
    end
    repeat (cycles) @(negedge clock);
  endtask

  // Pops the oldest expectation and compares it against the DUT outputs.
  task automatic checkOutput();
    exp_t        e;
    logic [3:0]  o;
    logic [19:0] t;
    logic [9:0]  p;
    logic        a, h;
    checks++;
    assert (sb_q.size() != 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_empty observed 0 entries expected at least 1");
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      if (e.inst == 1'b0) begin
        o = orders_a; t = order_times_a; p = point_total_a; a = serve_ack_a; h = serve_hit_a;
      end else begin
        o = orders_b; t = order_times_b; p = point_total_b; a = serve_ack_b; h = serve_hit_b;
      end
      checks++;
      assert (o === e.orders) else begin
        errors++;
        $error("[TB] FAIL %s.orders observed %b expected %b", e.tag, o, e.orders);
      end
      checks++;
      assert (t === e.times) else begin
        errors++;
        $error("[TB] FAIL %s.order_times observed %h expected %h", e.tag, t, e.times);
      end
      checks++;
      assert (p === e.points) else begin
        errors++;
        $error("[TB] FAIL %s.point_total observed %0d expected %0d", e.tag, p, e.points);
      end
      checks++;
      assert (a === e.ack) else begin
        errors++;
        $error("[TB] FAIL %s.serve_ack observed %b expected %b", e.tag, a, e.ack);
      end
      checks++;
      assert (h === e.hit) else begin
        errors++;
        $error("[TB] FAIL %s.serve_hit observed %b expected %b", e.tag, h, e.hit);
      end
    end
  endtask

  // Guards against a stuck run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence; comments give the count of running edges so far.
  initial begin
    reset_a = 1'b1; game_state_a = 3'd0; serve_a = 1'b0;
    reset_b = 1'b1; game_state_b = 3'd0; serve_b = 1'b0;
    @(negedge clock);

    pushExpect("a_reset", 0, 0, ALL_IDLE, 0, 0, 0);
    applyStimulus(0, 1'b1, 3'd0, 1'b0, 2);
    checkOutput();

    applyStimulus(0, 1'b0, 3'd1, 1'b0, 1);

    pushExpect("a_before_first_tick", 0, 0, ALL_IDLE, 0, 0, 0);
    applyStimulus(0, 1'b0, 3'd2, 1'b0, 9);    // 9
    checkOutput();

    pushExpect("a_first_spawn", 0, 4'b0001, tv(31, 31, 31, 5), 0, 0, 0);
    applyStimulus(0, 1'b0, 3'd2, 1'b0, 1);    // 10
    checkOutput();

    pushExpect("a_slot0_last_second", 0, 4'b0011, tv(31, 31, 4, 1), 0, 0, 0);
    applyStimulus(0, 1'b0, 3'd2, 1'b0, 40);   // 50
    checkOutput();

    pushExpect("a_expire_floor", 0, 4'b0010, tv(31, 31, 3, 31), 0, 0, 0);
    applyStimulus(0, 1'b0, 3'd2, 1'b0, 10);   // 60
    checkOutput();

    pushExpect("a_two_active", 0, 4'b0011, tv(31, 31, 2, 5), 0, 0, 0);
    applyStimulus(0, 1'b0, 3'd2, 1'b0, 10);   // 70
    checkOutput();

    pushExpect("a_serve_min_time", 0, 4'b0001, tv(31, 31, 31, 5), 22, 1, 1);
    applyStimulus(0, 1'b0, 3'd2, 1'b1, 1);    // 71
    checkOutput();

    pushExpect("a_ack_one_cycle", 0, 4'b0001, tv(31, 31, 31, 5), 22, 0, 0);
    applyStimulus(0, 1'b0, 3'd2, 1'b0, 1);    // 72
    checkOutput();

    applyStimulus(0, 1'b0, 3'd3, 1'b0, 1);
    pushExpect("a_pause_serve_ignored", 0, 4'b0001, tv(31, 31, 31, 5), 22, 0, 0);
    applyStimulus(0, 1'b0, 3'd3, 1'b1, 1);
    checkOutput();

    pushExpect("a_pause_frozen", 0, 4'b0001, tv(31, 31, 31, 5), 22, 0, 0);
    applyStimulus(0, 1'b0, 3'd3, 1'b0, 50);
    checkOutput();

    pushExpect("a_expire_penalty", 0, 4'b0010, tv(31, 31, 3, 31), 12, 0, 0);
    applyStimulus(0, 1'b0, 3'd2, 1'b0, 48);   // 120
    checkOutput();

    pushExpect("a_serve_last_order", 0, 0, ALL_IDLE, 35, 1, 1);
    applyStimulus(0, 1'b0, 3'd2, 1'b1, 1);    // 121
    checkOutput();

    pushExpect("a_serve_empty_board", 0, 0, ALL_IDLE, 35, 1, 0);
    applyStimulus(0, 1'b0, 3'd2, 1'b1, 1);    // 122
    checkOutput();

    pushExpect("a_no_serve", 0, 0, ALL_IDLE, 35, 0, 0);
    applyStimulus(0, 1'b0, 3'd2, 1'b0, 1);    // 123
    checkOutput();

    pushExpect("a_intro_clears", 0, 0, ALL_IDLE, 0, 0, 0);
    applyStimulus(0, 1'b0, 3'd1, 1'b0, 1);
    checkOutput();
    applyStimulus(0, 1'b0, 3'd0, 1'b0, 0);

    applyStimulus(1, 1'b0, 3'd1, 1'b0, 1);

    pushExpect("b_board_full", 1, 4'b1111, tv(30, 29, 28, 27), 0, 0, 0);
    applyStimulus(1, 1'b0, 3'd2, 1'b0, 16);   // 16
    checkOutput();

    pushExpect("b_spawn_dropped", 1, 4'b1111, tv(29, 28, 27, 26), 0, 0, 0);
    applyStimulus(1, 1'b0, 3'd2, 1'b0, 4);    // 20
    checkOutput();

    applyStimulus(1, 1'b0, 3'd2, 1'b0, 3);    // 23
    pushExpect("b_serve_on_tick", 1, 4'b1110, tv(28, 27, 26, 31), 526, 1, 1);
    applyStimulus(1, 1'b0, 3'd2, 1'b1, 1);    // 24
    checkOutput();

    pushExpect("b_respawn_next_tick", 1, 4'b1111, tv(27, 26, 25, 30), 526, 0, 0);
    applyStimulus(1, 1'b0, 3'd2, 1'b0, 4);    // 28
    checkOutput();

    pushExpect("b_saturate", 1, 4'b1101, tv(27, 26, 31, 30), 1023, 1, 1);
    applyStimulus(1, 1'b0, 3'd2, 1'b1, 1);    // 29
    checkOutput();

    pushExpect("b_saturate_hold", 1, 4'b1001, tv(27, 31, 31, 30), 1023, 1, 1);
    applyStimulus(1, 1'b0, 3'd2, 1'b1, 1);    // 30
    checkOutput();

    pushExpect("b_reset_drops_ack", 1, 0, ALL_IDLE, 0, 0, 0);
    applyStimulus(1, 1'b1, 3'd2, 1'b1, 1);
    checkOutput();
    applyStimulus(1, 1'b1, 3'd0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
